// File: rtl/msd_job_sequencer.sv
// Round-robin job sequencer sharing one MSD divide/sqrt/multiply unit between requesters A and B.
// Optional WAIT_RDY watchdog with MSD resync strobe is enabled by defining MSD_SEQ_WATCHDOG_EN.
module msd_job_sequencer #(
  parameter int WORD_LENGHT = 16,
  parameter int LOAD_WAIT   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_req,
  input  logic [1:0]             a_opcode,
  input  logic [WORD_LENGHT-1:0] a_op_x,
  input  logic [WORD_LENGHT-1:0] a_op_y,
  output logic                   a_gnt,
  input  logic                   b_req,
  input  logic [1:0]             b_opcode,
  input  logic [WORD_LENGHT-1:0] b_op_x,
  input  logic [WORD_LENGHT-1:0] b_op_y,
  output logic                   b_gnt,
  output logic                   msd_start,
  output logic                   msd_load,
  output logic [1:0]             msd_opcode,
  output logic [WORD_LENGHT-1:0] msd_data,
  input  logic                   msd_load_x,
  input  logic                   msd_load_y,
  input  logic                   msd_ready_flag,
  input  logic                   msd_error_flag,
  input  logic [WORD_LENGHT-1:0] msd_result,
  input  logic [WORD_LENGHT-1:0] msd_residue,
  output logic                   done,
  output logic                   done_id,
  output logic [WORD_LENGHT-1:0] res,
  output logic [WORD_LENGHT-1:0] rem,
  output logic                   err,
  output logic                   busy
);

  localparam int CW = $clog2(LOAD_WAIT) + 1;

  localparam logic [1:0] OP_SQRT = 2'b01;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD_X,
    S_LOAD_Y,
    S_WAIT_RDY,
    S_RESP,
    S_RESYNC
  } state_t;

  state_t state, state_next;

  logic                   rr_last;
  logic [1:0]             job_op;
  logic [WORD_LENGHT-1:0] job_x;
  logic [WORD_LENGHT-1:0] job_y;
  logic                   job_id;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_inc;

  logic [WORD_LENGHT-1:0] cap_res;
  logic [WORD_LENGHT-1:0] cap_rem;
  logic                   cap_err;

  logic                   grant_a;
  logic                   grant_b;
  logic                   cap_en;
  logic [WORD_LENGHT-1:0] cap_res_n;
  logic [WORD_LENGHT-1:0] cap_rem_n;
  logic                   cap_err_n;

`ifdef MSD_SEQ_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        wd_fired;
  logic        wd_trip;
`endif

  assign cnt_inc = cnt + 1'b1;
  assign busy    = (state != S_IDLE);

  // Next-state, arbitration, MSD bus drive and response capture selection.
  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    cap_en     = 1'b0;
    cap_res_n  = '0;
    cap_rem_n  = '0;
    cap_err_n  = 1'b0;
    msd_start  = 1'b0;
    msd_load   = 1'b0;
    msd_opcode = 2'b00;
    msd_data   = '0;
`ifdef MSD_SEQ_WATCHDOG_EN
    wd_trip    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // rr_last high means B went last, so A wins a tie.
        if (a_req && (!b_req || rr_last)) begin
          grant_a = 1'b1;
        end else if (b_req) begin
          grant_b = 1'b1;
        end
        if (grant_a || grant_b) begin
          state_next = S_START;
        end
      end
      S_START: begin
        if (job_op == OP_ILL) begin
          cap_en     = 1'b1;
          cap_res_n  = '1;
          cap_rem_n  = '0;
          cap_err_n  = 1'b1;
          state_next = S_RESP;
        end else begin
          msd_start  = 1'b1;
          msd_opcode = job_op;
          msd_data   = job_x;
          state_next = S_LOAD_X;
        end
      end
      S_LOAD_X: begin
        msd_load   = 1'b1;
        msd_opcode = job_op;
        msd_data   = job_x;
        if (msd_load_x) begin
          state_next = (job_op == OP_SQRT) ? S_WAIT_RDY : S_LOAD_Y;
        end else if (cnt_inc == CW'(LOAD_WAIT)) begin
          cap_en     = 1'b1;
          cap_err_n  = 1'b1;
          state_next = S_RESP;
        end
      end
      S_LOAD_Y: begin
        msd_load   = 1'b1;
        msd_opcode = job_op;
        msd_data   = job_y;
        if (msd_load_y) begin
          state_next = S_WAIT_RDY;
        end else if (cnt_inc == CW'(LOAD_WAIT)) begin
          cap_en     = 1'b1;
          cap_err_n  = 1'b1;
          state_next = S_RESP;
        end
      end
      S_WAIT_RDY: begin
        // Keep the last loaded operand on the bus until the MSD finishes.
        msd_opcode = job_op;
        msd_data   = (job_op == OP_SQRT) ? job_x : job_y;
        if (msd_ready_flag) begin
          cap_en     = 1'b1;
          cap_res_n  = msd_result;
          cap_rem_n  = msd_residue;
          cap_err_n  = msd_error_flag;
          state_next = S_RESP;
        end
`ifdef MSD_SEQ_WATCHDOG_EN
        else if (wd_cnt == 16'hFFFE) begin
          cap_en     = 1'b1;
          cap_err_n  = 1'b1;
          wd_trip    = 1'b1;
          state_next = S_RESP;
        end
`endif
      end
      S_RESP: begin
`ifdef MSD_SEQ_WATCHDOG_EN
        state_next = wd_fired ? S_RESYNC : S_IDLE;
`else
        state_next = S_IDLE;
`endif
      end
`ifdef MSD_SEQ_WATCHDOG_EN
      S_RESYNC: begin
        msd_start  = 1'b1;
        msd_opcode = OP_ILL;
        state_next = S_IDLE;
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, job latch, capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rr_last <= 1'b1;
      job_op  <= 2'b00;
      job_x   <= '0;
      job_y   <= '0;
      job_id  <= 1'b0;
      cnt     <= '0;
      cap_res <= '0;
      cap_rem <= '0;
      cap_err <= 1'b0;
      a_gnt   <= 1'b0;
      b_gnt   <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      res     <= '0;
      rem     <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? '0 : cnt_inc;
      a_gnt <= grant_a;
      b_gnt <= grant_b;
      if (grant_a || grant_b) begin
        job_op  <= grant_a ? a_opcode : b_opcode;
        job_x   <= grant_a ? a_op_x : b_op_x;
        job_y   <= grant_a ? a_op_y : b_op_y;
        job_id  <= grant_b;
        rr_last <= grant_b;
      end
      if (cap_en) begin
        cap_res <= cap_res_n;
        cap_rem <= cap_rem_n;
        cap_err <= cap_err_n;
      end
      done <= (state == S_RESP);
      if (state == S_RESP) begin
        done_id <= job_id;
        res     <= cap_res;
        rem     <= cap_rem;
        err     <= cap_err;
      end
    end
  end

`ifdef MSD_SEQ_WATCHDOG_EN
  // Watchdog counts WAIT_RDY cycles; a trip forces one resync strobe after RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt   <= '0;
      wd_fired <= 1'b0;
    end else begin
      wd_cnt <= (state == S_WAIT_RDY && state_next == S_WAIT_RDY) ? wd_cnt + 16'd1 : 16'd0;
      if (wd_trip) begin
        wd_fired <= 1'b1;
      end else if (state == S_RESYNC) begin
        wd_fired <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_msd_job_sequencer.sv
// Directed bench for msd_job_sequencer with a behavioural MSD responder.
module tb_msd_job_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0;
  logic [1:0]  a_opcode = 2'b00;
  logic [15:0] a_op_x = 16'h0;
  logic [15:0] a_op_y = 16'h0;
  logic        a_gnt;
  logic        b_req = 1'b0;
  logic [1:0]  b_opcode = 2'b00;
  logic [15:0] b_op_x = 16'h0;
  logic [15:0] b_op_y = 16'h0;
  logic        b_gnt;
  logic        msd_start;
  logic        msd_load;
  logic [1:0]  msd_opcode;
  logic [15:0] msd_data;
  logic        msd_load_x = 1'b0;
  logic        msd_load_y = 1'b0;
  logic        msd_ready_flag = 1'b0;
  logic        msd_error_flag = 1'b0;
  logic [15:0] msd_result = 16'h0;
  logic [15:0] msd_residue = 16'h0;
  logic        done;
  logic        done_id;
  logic [15:0] res;
  logic [15:0] rem;
  logic        err;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  int start_cnt = 0;
  int load_cnt = 0;
  int overlap_cnt = 0;
  int ready_delay = 10;
  logic ack_x_en = 1'b1;

  int s_start;
  int s_load;
  int done_seen;

  msd_job_sequencer #(.WORD_LENGHT(16), .LOAD_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_opcode(a_opcode), .a_op_x(a_op_x), .a_op_y(a_op_y), .a_gnt(a_gnt),
    .b_req(b_req), .b_opcode(b_opcode), .b_op_x(b_op_x), .b_op_y(b_op_y), .b_gnt(b_gnt),
    .msd_start(msd_start), .msd_load(msd_load), .msd_opcode(msd_opcode), .msd_data(msd_data),
    .msd_load_x(msd_load_x), .msd_load_y(msd_load_y), .msd_ready_flag(msd_ready_flag),
    .msd_error_flag(msd_error_flag), .msd_result(msd_result), .msd_residue(msd_residue),
    .done(done), .done_id(done_id), .res(res), .rem(rem), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] isqrt(input logic [15:0] v);
    logic [15:0] r;
    r = 16'h0;
    for (int i = 0; i < 256; i++) begin
      if (i * i <= int'(v)) r = 16'(i);
    end
    return r;
  endfunction

  // Behavioural MSD: acks each load one cycle after it appears, answers after ready_delay cycles.
  typedef enum logic [1:0] {PH_IDLE, PH_X, PH_Y, PH_WAIT} phase_t;
  phase_t      phase = PH_IDLE;
  logic [1:0]  m_op = 2'b00;
  logic [15:0] m_x = 16'h0;
  logic [15:0] m_y = 16'h0;
  logic [31:0] m_p;
  int          wcnt = 0;

  always @(negedge clk) begin
    msd_load_x     = 1'b0;
    msd_load_y     = 1'b0;
    msd_ready_flag = 1'b0;
    if (rst) begin
      phase = PH_IDLE;
    end else begin
      if (msd_start && msd_load) overlap_cnt++;
      if (msd_start) begin
        start_cnt++;
        m_op  = msd_opcode;
        phase = PH_X;
      end else if (msd_load) begin
        load_cnt++;
        if (phase == PH_X && ack_x_en) begin
          m_x        = msd_data;
          msd_load_x = 1'b1;
          phase      = (m_op == 2'b01) ? PH_WAIT : PH_Y;
          wcnt       = 0;
        end else if (phase == PH_Y) begin
          m_y        = msd_data;
          msd_load_y = 1'b1;
          phase      = PH_WAIT;
          wcnt       = 0;
        end
      end else if (phase == PH_WAIT) begin
        wcnt++;
        if (wcnt >= ready_delay) begin
          msd_error_flag = 1'b0;
          case (m_op)
            2'b00: begin
              if (m_y == 16'h0) begin
                msd_result     = 16'hFFFF;
                msd_residue    = m_x;
                msd_error_flag = 1'b1;
              end else begin
                msd_result  = m_x / m_y;
                msd_residue = m_x % m_y;
              end
            end
            2'b01: begin
              msd_result  = isqrt(m_x);
              msd_residue = m_x - msd_result * msd_result;
            end
            default: begin
              m_p         = {16'h0, m_x} * {16'h0, m_y};
              msd_result  = m_p[15:0];
              msd_residue = m_p[31:16];
            end
          endcase
          msd_ready_flag = 1'b1;
          phase          = PH_IDLE;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) begin
      pass_cnt++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic id, input logic req, input logic [1:0] op,
                               input logic [15:0] x, input logic [15:0] y);
    if (id == 1'b0) begin
      a_req = req; a_opcode = op; a_op_x = x; a_op_y = y;
    end else begin
      b_req = req; b_opcode = op; b_op_x = x; b_op_y = y;
    end
  endtask

  task automatic waitDone(input string tag, input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < max_cycles);
    checkOutput({tag, "_done"}, {31'h0, done}, 32'd1);
  endtask

  task automatic checkResp(input string tag, input logic id, input logic [15:0] r,
                           input logic [15:0] m, input logic e);
    checkOutput({tag, "_id"}, {31'h0, done_id}, {31'h0, id});
    checkOutput({tag, "_res"}, {16'h0, res}, {16'h0, r});
    checkOutput({tag, "_rem"}, {16'h0, rem}, {16'h0, m});
    checkOutput({tag, "_err"}, {31'h0, err}, {31'h0, e});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_busy", {31'h0, busy}, 32'd0);
    checkOutput("rst_done", {31'h0, done}, 32'd0);
    checkOutput("rst_gnt", {30'h0, a_gnt, b_gnt}, 32'd0);
    checkOutput("rst_strobes", {30'h0, msd_start, msd_load}, 32'd0);
    checkOutput("rst_res", {16'h0, res}, 32'd0);
    checkOutput("rst_err", {31'h0, err}, 32'd0);

    $display("[TB] A mult 3*4");
    s_start = start_cnt; s_load = load_cnt;
    applyStimulus(1'b0, 1'b1, 2'b10, 16'h0003, 16'h0004);
    @(negedge clk);
    checkOutput("mult_gnt", {30'h0, a_gnt, b_gnt}, 32'd2);
    checkOutput("mult_busy", {31'h0, busy}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b10, 16'h0003, 16'h0004);
    waitDone("mult", 40);
    checkResp("mult", 1'b0, 16'h000C, 16'h0000, 1'b0);
    checkOutput("mult_starts", 32'(start_cnt - s_start), 32'd1);
    checkOutput("mult_loads", 32'(load_cnt - s_load), 32'd2);
    @(negedge clk);
    checkOutput("mult_done_pulse", {31'h0, done}, 32'd0);
    checkOutput("mult_res_held", {16'h0, res}, 32'h000C);

    $display("[TB] B sqrt 0x51");
    ready_delay = 3;
    s_start = start_cnt; s_load = load_cnt;
    applyStimulus(1'b1, 1'b1, 2'b01, 16'h0051, 16'h1234);
    @(negedge clk);
    checkOutput("sqrt_gnt", {30'h0, a_gnt, b_gnt}, 32'd1);
    applyStimulus(1'b1, 1'b0, 2'b01, 16'h0051, 16'h1234);
    waitDone("sqrt", 40);
    checkResp("sqrt", 1'b1, 16'h0009, 16'h0000, 1'b0);
    checkOutput("sqrt_loads", 32'(load_cnt - s_load), 32'd1);

    $display("[TB] simultaneous div requests");
    ready_delay = 10;
    applyStimulus(1'b0, 1'b1, 2'b00, 16'd100, 16'd7);
    applyStimulus(1'b1, 1'b1, 2'b00, 16'd50, 16'd5);
    @(negedge clk);
    checkOutput("tie1_gnt", {30'h0, a_gnt, b_gnt}, 32'd2);
    applyStimulus(1'b0, 1'b0, 2'b00, 16'd100, 16'd7);
    repeat (2) @(negedge clk);
    checkOutput("tie1_b_waits", {31'h0, b_gnt}, 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b00, 16'd9, 16'd3);
    waitDone("tie1_a", 40);
    checkResp("tie1_a", 1'b0, 16'h000E, 16'h0002, 1'b0);
    @(negedge clk);
    checkOutput("tie2_gnt", {30'h0, a_gnt, b_gnt}, 32'd1);
    applyStimulus(1'b1, 1'b0, 2'b00, 16'd50, 16'd5);
    waitDone("tie2_b", 40);
    checkResp("tie2_b", 1'b1, 16'h000A, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("tie2_a_gnt", {30'h0, a_gnt, b_gnt}, 32'd2);
    applyStimulus(1'b0, 1'b0, 2'b00, 16'd9, 16'd3);
    waitDone("tie2_a", 40);
    checkResp("tie2_a", 1'b0, 16'h0003, 16'h0000, 1'b0);

    $display("[TB] illegal opcode");
    @(negedge clk);
    s_start = start_cnt; s_load = load_cnt;
    applyStimulus(1'b0, 1'b1, 2'b11, 16'h5555, 16'hAAAA);
    @(negedge clk);
    checkOutput("ill_gnt", {31'h0, a_gnt}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'b11, 16'h5555, 16'hAAAA);
    @(negedge clk);
    checkOutput("ill_done_early", {31'h0, done}, 32'd0);
    @(negedge clk);
    checkOutput("ill_done", {31'h0, done}, 32'd1);
    checkResp("ill", 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    checkOutput("ill_no_msd", 32'((start_cnt - s_start) + (load_cnt - s_load)), 32'd0);

    $display("[TB] load_x timeout");
    ack_x_en = 1'b0;
    s_load = load_cnt;
    applyStimulus(1'b0, 1'b1, 2'b00, 16'd5, 16'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'b00, 16'd5, 16'd1);
    waitDone("tmo", 40);
    checkResp("tmo", 1'b0, 16'h0000, 16'h0000, 1'b1);
    checkOutput("tmo_load_cycles", 32'(load_cnt - s_load), 32'd8);
    ack_x_en = 1'b1;

    $display("[TB] MSD error flag");
    applyStimulus(1'b1, 1'b1, 2'b00, 16'd7, 16'd0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 2'b00, 16'd7, 16'd0);
    waitDone("div0", 40);
    checkResp("div0", 1'b1, 16'hFFFF, 16'h0007, 1'b1);

    $display("[TB] reset during WAIT_RDY");
    ready_delay = 40;
    applyStimulus(1'b0, 1'b1, 2'b10, 16'd2, 16'd3);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'b10, 16'd2, 16'd3);
    repeat (8) @(negedge clk);
    checkOutput("mid_busy", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", {31'h0, busy}, 32'd0);
    checkOutput("abort_strobes", {30'h0, msd_start, msd_load}, 32'd0);
    checkOutput("abort_done", {31'h0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_delay = 10;
    done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);
    applyStimulus(1'b0, 1'b1, 2'b10, 16'd5, 16'd6);
    @(negedge clk);
    checkOutput("post_gnt", {30'h0, a_gnt, b_gnt}, 32'd2);
    applyStimulus(1'b0, 1'b0, 2'b10, 16'd5, 16'd6);
    waitDone("post", 40);
    checkResp("post", 1'b0, 16'h001E, 16'h0000, 1'b0);

    checkOutput("start_load_overlap", 32'(overlap_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
